// File: rtl/jtcps1_lbuf_pkg.sv
// jtcps1_lbuf_pkg - shared constants and bank-select encoding for the CPS1 line buffer.
// Contents:
//   LBUF_AW / LBUF_DW / LBUF_BLANK : default address width, pixel width, transparent pixel
//   LBUF_LEN                        : pixels per line (2**LBUF_AW)
//   bank_e                          : which of the two line banks is selected
//   bank_other()                    : the opposite bank
package jtcps1_lbuf_pkg;

  localparam int         LBUF_AW    = 9;
  localparam int         LBUF_DW    = 8;
  localparam logic [7:0] LBUF_BLANK = 8'hff;
  localparam int         LBUF_LEN   = 1 << LBUF_AW;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic bank_e bank_other(input bank_e b);
    case (b)
      BANK_0:  return BANK_1;
      BANK_1:  return BANK_0;
      default: return BANK_0;
    endcase
  endfunction

endpackage

// File: rtl/jtcps1_linebuf_bank.sv
// jtcps1_linebuf_bank - one 2**AW x DW scanline bank.
// One write port, one synchronous read port. A read and a write to the same
// address in the same clk return the old contents (read-before-write).
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i: write port
//   re_i/raddr_i        : read enable / address
//   rdata_o             : registered read data, BLANK after reset, holds when re_i=0
module jtcps1_linebuf_bank #(
  parameter int            AW    = 9,
  parameter int            DW    = 8,
  parameter logic [DW-1:0] BLANK = 8'hff
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  // RAM array write port (contents deliberately not reset)
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered read port; non-blocking update gives read-before-write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= BLANK;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/jtcps1_linebuf.sv
// jtcps1_linebuf - double-buffered scanline store behind the CPS1 tilemap.
// The tilemap fills the write bank while the other bank is read at pixel rate.
// Banks swap on line_start_i, which also pulses start_o and flags underrun_o
// when the tilemap had not reported done_i since the previous swap.
// Ports:
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   pxl_cen_i                       : pixel clock enable (read side)
//   line_start_i                    : one-clk pulse at start of each displayed line
//   start_o                         : one-clk pulse asking the tilemap to render the next line
//   done_i                          : tilemap finished its line (level or pulse)
//   buf_addr_i/buf_data_i/buf_wr_i  : tilemap write port into the write bank
//   pxl_o                           : pixel to the colour mixer
//   underrun_o                      : one-clk pulse, line_start_i arrived before done_i
// Build option: define JTCPS1_LBUF_CLEAR_EN to overwrite each displayed pixel
// with BLANK as it is read, so undrawn pixels read transparent next time.
module jtcps1_linebuf
  import jtcps1_lbuf_pkg::*;
#(
  parameter int            AW    = LBUF_AW,
  parameter int            DW    = LBUF_DW,
  parameter logic [DW-1:0] BLANK = LBUF_BLANK
) (
  input  logic          rst_i,
  input  logic          clk_i,
  input  logic          pxl_cen_i,
  input  logic          line_start_i,
  output logic          start_o,
  input  logic          done_i,
  input  logic [AW-1:0] buf_addr_i,
  input  logic [DW-1:0] buf_data_i,
  input  logic          buf_wr_i,
  output logic [DW-1:0] pxl_o,
  output logic          underrun_o
);

  bank_e         wr_bank_q, wr_bank_d;
  bank_e         rd_sel_q, rd_sel_d;   // bank whose read register drives pxl_o
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          start_q, start_d;
  logic          underrun_q, underrun_d;
  logic          done_seen_q, done_seen_d;

  bank_e         rd_bank_s;
  logic          rd_fire_s;
  logic [1:0]    bank_we_s;
  logic [1:0]    bank_re_s;
  logic [AW-1:0] bank_waddr_s [2];
  logic [DW-1:0] bank_wdata_s [2];
  logic [DW-1:0] bank_rdata_s [2];

  assign rd_bank_s = bank_other(wr_bank_q);
  // line_start wins over a coincident pixel enable
  assign rd_fire_s = pxl_cen_i & ~line_start_i;

  // Per-bank port steering: write bank takes tilemap writes, display bank takes reads/clears
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      bank_re_s[b] = rd_fire_s & (rd_bank_s == bank_e'(b[0]));
      if (wr_bank_q == bank_e'(b[0])) begin
        bank_we_s[b]    = buf_wr_i;
        bank_waddr_s[b] = buf_addr_i;
        bank_wdata_s[b] = buf_data_i;
      end else begin
`ifdef JTCPS1_LBUF_CLEAR_EN
        bank_we_s[b]    = rd_fire_s;
`else
        bank_we_s[b]    = 1'b0;
`endif
        bank_waddr_s[b] = rd_addr_q;
        bank_wdata_s[b] = BLANK;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    jtcps1_linebuf_bank #(
      .AW    (AW),
      .DW    (DW),
      .BLANK (BLANK)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .we_i    (bank_we_s[g]),
      .waddr_i (bank_waddr_s[g]),
      .wdata_i (bank_wdata_s[g]),
      .re_i    (bank_re_s[g]),
      .raddr_i (rd_addr_q),
      .rdata_o (bank_rdata_s[g])
    );
  end

  // Next-state: swap/pulse on line_start, otherwise advance the read pointer on pixel enable
  always_comb begin
    wr_bank_d   = wr_bank_q;
    rd_sel_d    = rd_sel_q;
    rd_addr_d   = rd_addr_q;
    done_seen_d = done_seen_q | done_i;
    start_d     = 1'b0;
    underrun_d  = 1'b0;
    if (line_start_i) begin
      wr_bank_d   = rd_bank_s;
      rd_addr_d   = {AW{1'b0}};
      done_seen_d = 1'b0;
      start_d     = 1'b1;
      underrun_d  = ~(done_seen_q | done_i);
    end else if (pxl_cen_i) begin
      rd_addr_d = rd_addr_q + {{(AW-1){1'b0}}, 1'b1};
      rd_sel_d  = rd_bank_s;
    end else begin
      rd_addr_d = rd_addr_q;
    end
  end

  // Control state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_bank_q   <= BANK_0;
      rd_sel_q    <= BANK_0;
      rd_addr_q   <= {AW{1'b0}};
      done_seen_q <= 1'b1;
      start_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      wr_bank_q   <= wr_bank_d;
      rd_sel_q    <= rd_sel_d;
      rd_addr_q   <= rd_addr_d;
      done_seen_q <= done_seen_d;
      start_q     <= start_d;
      underrun_q  <= underrun_d;
    end
  end

  // Both bank read registers only change on a read, so this select keeps pxl_o steady between enables
  assign pxl_o      = (rd_sel_q == BANK_1) ? bank_rdata_s[1] : bank_rdata_s[0];
  assign start_o    = start_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_jtcps1_linebuf.sv
module tb_jtcps1_linebuf;

  localparam logic [7:0] BLANK = 8'hff;
`ifdef JTCPS1_LBUF_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       line_start = 1'b0;
  logic       done = 1'b0;
  logic [8:0] buf_addr = 9'd0;
  logic [7:0] buf_data = 8'd0;
  logic       buf_wr = 1'b0;
  logic       start;
  logic       underrun;
  logic [7:0] pxl;

  int tests = 0;
  int fails = 0;

  jtcps1_linebuf dut (
    .rst_i        (rst),
    .clk_i        (clk),
    .pxl_cen_i    (pxl_cen),
    .line_start_i (line_start),
    .start_o      (start),
    .done_i       (done),
    .buf_addr_i   (buf_addr),
    .buf_data_i   (buf_data),
    .buf_wr_i     (buf_wr),
    .pxl_o        (pxl),
    .underrun_o   (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: two line stores addressed by (bank, pixel) ----------------
  logic [7:0] m_mem [0:1023];
  bit         m_val [0:1023];
  int         m_wb, m_ri;
  bit         m_seen, m_start, m_under, m_known, model_ok;
  logic [7:0] m_pxl;

  initial begin
    for (int i = 0; i < 1024; i++) m_val[i] = 1'b0;
    model_ok = 1'b0;
  end

  always @(posedge clk) begin
    int ridx;
    if (rst) begin
      m_wb = 0; m_ri = 0; m_pxl = BLANK; m_known = 1'b1;
      m_start = 1'b0; m_under = 1'b0; m_seen = 1'b1; model_ok = 1'b1;
    end else begin
      if (buf_wr) begin
        m_mem[m_wb*512 + int'(buf_addr)] = buf_data;
        m_val[m_wb*512 + int'(buf_addr)] = 1'b1;
      end
      if (line_start) begin
        m_under = !(m_seen || done);
        m_start = 1'b1;
        m_wb    = 1 - m_wb;
        m_ri    = 0;
        m_seen  = 1'b0;
      end else begin
        m_start = 1'b0;
        m_under = 1'b0;
        if (done) m_seen = 1'b1;
        if (pxl_cen) begin
          ridx    = (1 - m_wb)*512 + m_ri;
          m_known = m_val[ridx];
          m_pxl   = m_mem[ridx];
          if (CLR) begin
            m_mem[ridx] = BLANK;
            m_val[ridx] = 1'b1;
          end
          m_ri = (m_ri + 1) % 512;
        end
      end
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (model_ok) begin
      check("model_start", int'(start), int'(m_start));
      check("model_underrun", int'(underrun), int'(m_under));
      if (m_known) check("model_pxl", int'(pxl), int'(m_pxl));
    end
  end

  // one clock of stimulus; inputs change just after a falling edge
  task automatic cyc(input logic ls, input logic cen, input logic dn,
                     input logic wr, input logic [8:0] a, input logic [7:0] d);
    line_start = ls; pxl_cen = cen; done = dn; buf_wr = wr; buf_addr = a; buf_data = d;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
  endtask

  initial begin
    logic [8:0] a9;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state held until the first line_start
    for (int k = 0; k < 5; k++) begin
      idle();
      check("rst_pxl", int'(pxl), 8'hff);
      check("rst_start", int'(start), 0);
      check("rst_underrun", int'(underrun), 0);
    end

    // fill bank 0 with addr[7:0], done, line_start
    for (int i = 0; i < 512; i++) begin
      a9 = 9'(i);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, a9, a9[7:0]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 8'd0);
    idle();
    check("pre_start", int'(start), 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    check("ls1_start", int'(start), 1);
    check("ls1_underrun", int'(underrun), 0);
    idle();
    check("ls1_start_pulse", int'(start), 0);

    // display bank 0 while filling bank 1 with 3c; 513th enable wraps
    for (int k = 1; k <= 513; k++) begin
      a9 = 9'(k - 1);
      cyc(1'b0, 1'b1, (k == 513), (k <= 512), a9, 8'h3c);
      if (k == 1)   check("rd_px0", int'(pxl), 8'h00);
      if (k == 256) check("rd_px255", int'(pxl), 8'hff);
      if (k == 257) check("rd_px256", int'(pxl), 8'h00);
      if (k == 512) check("rd_px511", int'(pxl), 8'hff);
      if (k == 513) check("rd_wrap", int'(pxl), CLR ? 8'hff : 8'h00);
    end

    // display bank 1 (3c)
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    check("ls2_start", int'(start), 1);
    check("ls2_underrun", int'(underrun), 0);
    for (int k = 1; k <= 512; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
      if (k == 1)   check("b1_px0", int'(pxl), 8'h3c);
      if (k == 512) check("b1_px511", int'(pxl), 8'h3c);
    end

    // no done since previous start -> underrun, start still pulsed
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    check("ur_flag", int'(underrun), 1);
    check("ur_start", int'(start), 1);
    idle();
    check("ur_pulse", int'(underrun), 0);

    // second swap without writes: bank 1 displayed again
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0);
    check("ur2_flag", int'(underrun), 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
    check("stale_px0", int'(pxl), CLR ? 8'hff : 8'h3c);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
    check("stale_px1", int'(pxl), CLR ? 8'hff : 8'h3c);

    // line_start + pxl_cen + write addr 5 in the same clk
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 9'd5, 8'h77);
    check("coinc_hold", int'(pxl), CLR ? 8'hff : 8'h3c);
    check("coinc_start", int'(start), 1);
    for (int k = 1; k <= 6; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
      if (k == 1) check("coinc_px0", int'(pxl), CLR ? 8'hff : 8'h00);
      if (k == 5) check("coinc_px4", int'(pxl), CLR ? 8'hff : 8'h04);
      if (k == 6) check("coinc_px5", int'(pxl), 8'h77);
    end
    idle();
    check("hold_between", int'(pxl), 8'h77);

    // reset mid-line
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 8'd0);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    check("mid_rst_pxl", int'(pxl), 8'hff);
    check("mid_rst_start", int'(start), 0);
    check("mid_rst_underrun", int'(underrun), 0);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("post_rst_start", int'(start), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
